// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES CTR-mode sequencer.
// block_t, FSM state enum, masked counter increment.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    UNCFG,
    READY,
    START,
    WAIT,
    OUT
  } ctr_state_e;

  typedef struct packed {
    logic   carry;
    block_t blk;
  } ctr_inc_t;

  // Increment the low w bits of b modulo 2^w; upper bits pass through.
  function automatic ctr_inc_t ctr_inc(block_t b, int unsigned w);
    block_t   m;
    ctr_inc_t r;
    m       = (w >= 128) ? '1 : ((block_t'(1) << w) - block_t'(1));
    r.blk   = (b & ~m) | (((b & m) + block_t'(1)) & m);
    r.carry = ((b & m) == m);
    return r;
  endfunction

endpackage

// File: rtl/aes_ctr_inc.sv
// Combinational masked counter increment with carry-out.
// Ports: i_ctr (block in), o_ctr (incremented block), o_carry (field wrapped).
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic [127:0] i_ctr,
  output logic [127:0] o_ctr,
  output logic         o_carry
);

  ctr_inc_t w_res;

  assign w_res   = ctr_inc(i_ctr, CTR_W);
  assign o_ctr   = w_res.blk;
  assign o_carry = w_res.carry;

endmodule

// File: rtl/aes_ctr_seq.sv
// CTR-mode sequencer around an external aes_top core.
// Ports: cfg_* (key/IV load), in_* / out_* (block streams),
//        aes_* (start/key/pt to core, busy/done/ct from core), ctr_wrap.
module aes_ctr_seq
  import aes_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  output logic         cfg_ready,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         ctr_wrap,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_pt,
  input  logic         aes_busy,
  input  logic         aes_done,
  input  logic [127:0] aes_ct
);

  ctr_state_e   r_state;
  ctr_state_e   w_next;

  logic [127:0] r_key;
  logic [127:0] r_ctr;
  logic [127:0] r_pt;
  logic [127:0] r_data;
  logic [127:0] r_out;
  logic         r_out_valid;
  logic         r_start;
  logic         r_wrap;

  logic [127:0] w_inc;
  logic         w_carry;
  logic         w_cfg;
  logic         w_acc;
  logic         w_done;
  logic         w_pop;

  aes_ctr_inc #(
    .CTR_W(CTR_W)
  ) u_inc (
    .i_ctr  (r_ctr),
    .o_ctr  (w_inc),
    .o_carry(w_carry)
  );

  assign cfg_ready = (r_state == UNCFG) || (r_state == READY);
  assign in_ready  = (r_state == READY);
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign ctr_wrap  = r_wrap;
  assign aes_start = r_start;
  assign aes_key   = r_key;
  assign aes_pt    = r_pt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= UNCFG;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_cfg  = 1'b0;
    w_acc  = 1'b0;
    w_done = 1'b0;
    w_pop  = 1'b0;
    unique case (r_state)
      UNCFG: begin
        if (cfg_load) begin
          w_cfg  = 1'b1;
          w_next = READY;
        end
      end
      READY: begin
        if (cfg_load) begin
          w_cfg = 1'b1;
        end else if (in_valid) begin
          w_acc  = 1'b1;
          w_next = START;
        end
      end
      // Leave only once the registered pulse has actually been shown.
      START: begin
        if (r_start) w_next = WAIT;
      end
      WAIT: begin
        if (aes_done) begin
          w_done = 1'b1;
          w_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          w_pop  = 1'b1;
          w_next = READY;
        end
      end
      default: w_next = UNCFG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key       <= '0;
      r_ctr       <= '0;
      r_pt        <= '0;
      r_data      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_cfg) begin
        r_key  <= cfg_key;
        r_ctr  <= cfg_iv;
        r_wrap <= 1'b0;
      end
      if (w_acc) begin
        r_data  <= in_data;
        r_pt    <= r_ctr;
        r_start <= ~aes_busy;
      end
      // Core busy: retry the pulse once it goes idle.
      if ((r_state == START) && !r_start) begin
        r_start <= ~aes_busy;
      end
      if (w_done) begin
        r_out       <= r_data ^ aes_ct;
        r_out_valid <= 1'b1;
        r_ctr       <= w_inc;
        if (w_carry) r_wrap <= 1'b1;
      end
      if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_seq.sv
// Self-checking bench for aes_ctr_seq with a stub AES core.
// Stub returns SP800-38A keystream for the known vectors.
module tb_aes_ctr_seq;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] KW  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IVW = 128'h0123456789abcdef01234567ffffffff;
  localparam logic [127:0] IVN = 128'h0123456789abcdef0123456700000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_load = 1'b0;
  logic         cfg_ready;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         ctr_wrap;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_pt;
  logic         aes_busy;
  logic         aes_done;
  logic [127:0] aes_ct;

  logic         st_busy, st_done, force_busy = 1'b0, inj_done = 1'b0;
  logic [127:0] st_ct;
  int           st_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] m_key, m_ctr;
  logic         m_wrap;
  logic [127:0] q_pt[$], q_key[$], q_out[$];
  logic         q_wrap[$];

  always #5 clk = ~clk;

  aes_ctr_seq #(.CTR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_ready(cfg_ready),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ctr_wrap(ctr_wrap), .aes_start(aes_start),
    .aes_key(aes_key), .aes_pt(aes_pt),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_ct(aes_ct)
  );

  function automatic logic [127:0] fake_aes(logic [127:0] k, logic [127:0] p);
    if (k == K && p == IV)  return KS1;
    if (k == K && p == IV2) return KS2;
    return {p[63:0], p[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  assign aes_busy = st_busy | force_busy;
  assign aes_done = st_done | inj_done;
  assign aes_ct   = st_ct;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_busy <= 1'b0; st_done <= 1'b0; st_cnt <= 0; st_ct <= '0;
    end else begin
      st_done <= 1'b0;
      if (st_cnt != 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1) begin
          st_done <= 1'b1;
          st_busy <= 1'b0;
        end
      end else if (aes_start) begin
        st_busy <= 1'b1;
        st_cnt  <= 4;
        st_ct   <= fake_aes(aes_key, aes_pt);
      end
    end
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (aes_start) begin
        if (q_pt.size() == 0) fail("spurious_aes_start");
        else begin
          chk("aes_pt", aes_pt, q_pt.pop_front());
          chk("aes_key", aes_key, q_key.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) fail("spurious_out");
        else begin
          chk("out_data", out_data, q_out.pop_front());
          chk("ctr_wrap", {127'd0, ctr_wrap}, {127'd0, q_wrap.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(logic [127:0] k, logic [127:0] iv);
    int n = 0;
    while (!cfg_ready && n < 100) begin tick(); n++; end
    if (!cfg_ready) fail("cfg_timeout");
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv;
    tick();
    cfg_load = 1'b0;
    m_key = k; m_ctr = iv; m_wrap = 1'b0;
  endtask

  task automatic send(logic [127:0] d);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) fail("in_ready_timeout");
    in_valid = 1'b1; in_data = d;
    q_pt.push_back(m_ctr);
    q_key.push_back(m_key);
    q_out.push_back(d ^ fake_aes(m_key, m_ctr));
    if (m_ctr[31:0] == 32'hffff_ffff) m_wrap = 1'b1;
    m_ctr[31:0] = m_ctr[31:0] + 32'd1;
    q_wrap.push_back(m_wrap);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output logic [127:0] pt);
    int n = 0;
    while (!aes_start && n < 50) begin tick(); n++; end
    if (!aes_start) fail("aes_start_timeout");
    pt = aes_pt;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) fail("out_valid_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) fail("idle_timeout");
  endtask

  logic [127:0] pt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_aes_start", {127'd0, aes_start}, 128'd0);
    chk("rst_ctr_wrap", {127'd0, ctr_wrap}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_aes_key", aes_key, 128'd0);
    chk("rst_aes_pt", aes_pt, 128'd0);
    #4 rst = 1'b0;
    tick();

    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("uncfg_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;

    cfg(K, IV);
    send(P1);
    wait_start(pt);
    chk("blk1_pt", pt, IV);
    wait_out();
    chk("blk1_ct", out_data, C1);
    wait_idle();
    send(P2);
    wait_start(pt);
    chk("blk2_pt", pt, IV2);
    wait_out();
    chk("blk2_ct", out_data, C2);
    wait_idle();

    cfg(K, IV);
    send(C1);
    wait_out();
    chk("decrypt", out_data, P1);
    wait_idle();

    cfg(KW, IVW);
    send(128'h1111);
    wait_out();
    chk("wrap_set", {127'd0, ctr_wrap}, 128'd1);
    wait_idle();
    send(128'h2222);
    wait_start(pt);
    chk("wrap_pt", pt, IVN);
    wait_out();
    wait_idle();
    cfg(KW, IVW);
    chk("wrap_clear", {127'd0, ctr_wrap}, 128'd0);

    out_ready = 1'b0;
    send(128'hdead_beef);
    wait_out();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_data", out_data, q_out[0]);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);

    force_busy = 1'b1;
    send(128'h3333);
    repeat (5) begin
      tick();
      chk("busy_hold", {127'd0, aes_start}, 128'd0);
    end
    force_busy = 1'b0;
    wait_out();
    wait_idle();

    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (3) begin
      tick();
      chk("stray_done", {127'd0, out_valid}, 128'd0);
    end

    send(128'h4444);
    wait_start(pt);
    tick();
    chk("wait_cfg_ready", {127'd0, cfg_ready}, 128'd0);
    cfg_load = 1'b1; cfg_key = ~K; cfg_iv = 128'h5;
    tick();
    cfg_load = 1'b0;
    wait_out();
    wait_idle();
    send(128'h5555);
    wait_out();
    wait_idle();

    send(128'h6666);
    wait_start(pt);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    q_pt.delete(); q_key.delete(); q_out.delete(); q_wrap.delete();
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_out_data", out_data, 128'd0);
    chk("mid_rst_aes_key", aes_key, 128'd0);
    chk("mid_rst_aes_pt", aes_pt, 128'd0);
    chk("mid_rst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;

    cfg(K, IV);
    send(P1);
    wait_out();
    chk("post_rst_ct", out_data, C1);
    wait_idle();
    tick();
    chk("queues_drained", 128'(q_out.size() + q_pt.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
